dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage and a debug/loader port.
//  The pipeline has priority. The debug port is guaranteed one access after STARVE_LIMIT contended cycles.
//  While debug owns the port, the block stalls the pipeline. It sits between the EX/MEM register and the data memory.
//  The memory has a combinational read and a write on the clk edge.
// PARAMETERS
//  ADDR_W        32  byte-address width for both requesters and the memory
//  STARVE_LIMIT  4   max consecutive contended cycles debug waits before forced grant (>=1)
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst            in   1       synchronous reset, active-high
//  pipe_req       in   1       MEM stage needs memory this cycle (load or store)
//  pipe_we        in   1       1=store, 0=load
//  pipe_word_byte in   1       1=word, 0=byte
//  pipe_addr      in   ADDR_W  pipeline byte address
//  pipe_wdata     in   32      pipeline store data
//  pipe_rdata     out  32      load data (combinational from mem_rdata)
//  pipe_stall     out  1       freeze PC/IF_ID/ID_EX/EX_MEM this cycle
//  dbg_req        in   1       debug access request; held with its fields until dbg_ack
//  dbg_we         in   1       1=write, 0=read
//  dbg_addr       in   ADDR_W  debug byte address (always word access)
//  dbg_wdata      in   32      debug write data
//  dbg_ack        out  1       one-cycle completion pulse
//  dbg_rdata      out  32      registered read data, valid with dbg_ack and held after
//  mem_en         out  1       memory access this cycle
//  mem_we         out  1       memory write enable
//  mem_word_byte  out  1       word/byte select to memory
//  mem_addr       out  ADDR_W  memory address
//  mem_wdata      out  32      memory write data
//  mem_rdata      in   32      memory combinational read data
// BEHAVIOUR
//  Reset: state=IDLE, wait_cnt=0. dbg_ack=0, dbg_rdata=0, pipe_stall=0.
//   Memory outputs follow the IDLE mux, so they read 0 when pipe_req=0.
//  States:
//   IDLE      pipeline owns the port
//   DBG_GRANT debug owns the port
//   DBG_ACK   pipeline owns the port; dbg_ack=1
//  IDLE / DBG_ACK mux:
//   mem_en=pipe_req, mem_we=pipe_req&pipe_we. Other mem_* come from pipe_*, zeroed when pipe_req=0.
//   pipe_stall=0.
//  DBG_GRANT mux:
//   mem_en=1, mem_we=dbg_we, mem_word_byte=1, mem_addr=dbg_addr, mem_wdata=dbg_wdata.
//   pipe_stall=pipe_req.
//   dbg_rdata<=mem_rdata at the clock edge when dbg_we=0. dbg_rdata is unchanged on writes.
//  pipe_rdata=mem_rdata in all states. The pipeline ignores it while stalled.
//  Transitions:
//   IDLE -> DBG_GRANT when dbg_req & (~pipe_req | wait_cnt==STARVE_LIMIT-1).
//   IDLE -> IDLE otherwise.
//   DBG_GRANT -> DBG_ACK, always after one cycle.
//   DBG_ACK -> IDLE, always. Debug drops dbg_req in the ack cycle.
//   A dbg_req seen in the DBG_ACK cycle is ignored. The next request is evaluated in IDLE.
//  wait_cnt:
//   +1 in IDLE when dbg_req&pipe_req and no grant, saturating at STARVE_LIMIT-1.
//   Cleared on entry to DBG_GRANT, or when dbg_req=0.
//  Latency:
//   Uncontended debug: ack 2 cycles after dbg_req is sampled.
//   Contended debug: ack at most STARVE_LIMIT+1 cycles after dbg_req is sampled.
//   Pipeline: zero added latency except the single stall cycle per debug grant.
//  Reset mid-operation (any state) -> IDLE next cycle. No ack, no dbg_rdata update. A pending debug access is dropped.
// TESTING
//  1 Reset: assert rst 2 cycles with pipe_req=dbg_req=0.
//    -> pipe_stall=0, dbg_ack=0, dbg_rdata=0, mem_en=0, mem_we=0.
//  2 Pipe store, no debug: pipe_req=1, we=1, word, addr=8, wdata=26.
//    -> same cycle mem_en=1, mem_we=1, mem_addr=8, mem_wdata=26, stall=0.
//  3 Debug read alone: mem[12]=2, dbg_req=1, we=0, addr=12 at cycle 0.
//    -> cycle 1 mem_addr=12, mem_word_byte=1.
//    -> cycle 2 dbg_ack=1, dbg_rdata=2.
//  4 Contention, STARVE_LIMIT=4: pipe_req=1 continuously, dbg_req=1 at cycle 0.
//    -> pipe served cycles 0-3.
//    -> cycle 4 pipe_stall=1, mem_addr=dbg_addr.
//    -> cycle 5 dbg_ack=1, stall=0.
//  5 Debug write then pipe load: dbg writes 0x1A to addr 16; pipe then loads addr 16.
//    -> pipe_rdata=0x1A.
//  6 rst=1 in the DBG_GRANT cycle.
//    -> next cycle state IDLE, dbg_ack never pulses, dbg_rdata stays 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - data memory port arbiter between pipeline MEM stage and debug port
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic              pipe_word_byte,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [31:0]       pipe_wdata,
    output logic [31:0]       pipe_rdata,
    output logic              pipe_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_word_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DBG_GRANT = 2'd1,
        S_DBG_ACK   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_dbg_ack;
    logic [31:0]      r_dbg_rdata;

    logic w_contended;
    logic w_grant;
    logic w_dbg_owns;

    // Debug wins the port when the pipeline is quiet or it has waited long enough.
    assign w_contended = dbg_req & pipe_req;
    assign w_grant     = (r_state == S_IDLE) & dbg_req & (~pipe_req | (r_wait_cnt == CNT_MAX));
    assign w_dbg_owns  = (r_state == S_DBG_GRANT);

    // Ownership FSM, starvation counter and registered debug response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dbg_ack <= 1'b0;
                    if (w_grant) begin
                        r_state    <= S_DBG_GRANT;
                        r_wait_cnt <= '0;
                    end else if (w_contended) begin
                        if (r_wait_cnt != CNT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                S_DBG_GRANT: begin
                    r_state    <= S_DBG_ACK;
                    r_dbg_ack  <= 1'b1;
                    r_wait_cnt <= '0;
                    if (!dbg_we) begin
                        r_dbg_rdata <= mem_rdata;
                    end
                end
                S_DBG_ACK: begin
                    // Any request visible here is stale; it is re-evaluated from IDLE.
                    r_state    <= S_IDLE;
                    r_dbg_ack  <= 1'b0;
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_dbg_ack  <= 1'b0;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Memory-side mux: debug fields while debug owns the port, gated pipeline fields otherwise.
    always_comb begin
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_word_byte = 1'b0;
        mem_addr      = '0;
        mem_wdata     = 32'd0;
        pipe_stall    = 1'b0;
        if (w_dbg_owns) begin
            mem_en        = 1'b1;
            mem_we        = dbg_we;
            mem_word_byte = 1'b1;
            mem_addr      = dbg_addr;
            mem_wdata     = dbg_wdata;
            pipe_stall    = pipe_req;
        end else if (pipe_req) begin
            mem_en        = 1'b1;
            mem_we        = pipe_we;
            mem_word_byte = pipe_word_byte;
            mem_addr      = pipe_addr;
            mem_wdata     = pipe_wdata;
        end
    end

    assign pipe_rdata = mem_rdata;
    assign dbg_ack    = r_dbg_ack;
    assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LIMIT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_req, pipe_we, pipe_word_byte;
    logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic        pipe_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic        mem_en, mem_we, mem_word_byte;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_word_byte(pipe_word_byte),
        .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata),
        .pipe_stall(pipe_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_word_byte(mem_word_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Byte-addressed 64-byte memory driven only by the DUT's memory port.
    logic [7:0] dut_mem [0:63];
    logic       mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) dut_mem[i] <= 8'd0;
        end else if (mem_en && mem_we) begin
            if (mem_word_byte) begin
                dut_mem[{mem_addr[5:2], 2'b00}] <= mem_wdata[7:0];
                dut_mem[{mem_addr[5:2], 2'b01}] <= mem_wdata[15:8];
                dut_mem[{mem_addr[5:2], 2'b10}] <= mem_wdata[23:16];
                dut_mem[{mem_addr[5:2], 2'b11}] <= mem_wdata[31:24];
            end else begin
                dut_mem[mem_addr[5:0]] <= mem_wdata[7:0];
            end
        end
    end

    always_comb begin
        mem_rdata = 32'd0;
        if (mem_word_byte)
            mem_rdata = {dut_mem[{mem_addr[5:2], 2'b11}], dut_mem[{mem_addr[5:2], 2'b10}],
                         dut_mem[{mem_addr[5:2], 2'b01}], dut_mem[{mem_addr[5:2], 2'b00}]};
        else
            mem_rdata = {24'd0, dut_mem[mem_addr[5:0]]};
    end

    // Reference: independent memory image plus a notion of who owns the port this cycle.
    logic [7:0]  ref_mem [0:63];
    int          m_phase;      // 0 pipeline owns, 1 debug access cycle, 2 debug ack cycle
    int          m_refused;    // cycles debug has been refused because the pipeline was busy
    logic [31:0] m_rdata;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int dbg_start = 0;
    logic dbg_pending = 1'b0;

    function automatic logic [31:0] ref_read(input logic [5:0] a, input logic wb);
        if (wb) return {ref_mem[{a[5:2], 2'b11}], ref_mem[{a[5:2], 2'b10}],
                        ref_mem[{a[5:2], 2'b01}], ref_mem[{a[5:2], 2'b00}]};
        return {24'd0, ref_mem[a]};
    endfunction

    task automatic ref_write(input logic [5:0] a, input logic wb, input logic [31:0] d);
        if (wb) begin
            for (int b = 0; b < 4; b++) ref_mem[{a[5:2], 2'(b)}] = d[8*b +: 8];
        end else begin
            ref_mem[a] = d[7:0];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Compare every DUT output with what the reference says for the current inputs.
    task automatic sample();
        logic        e_en, e_we, e_wb, e_stall;
        logic [31:0] e_addr, e_wdata, e_rd;
        @(negedge clk);
        if (m_phase == 1) begin
            e_en = 1'b1; e_we = dbg_we; e_wb = 1'b1;
            e_addr = dbg_addr; e_wdata = dbg_wdata; e_stall = pipe_req;
        end else begin
            e_en = pipe_req; e_we = pipe_req & pipe_we; e_wb = pipe_req & pipe_word_byte;
            e_addr = pipe_req ? pipe_addr : 32'd0;
            e_wdata = pipe_req ? pipe_wdata : 32'd0;
            e_stall = 1'b0;
        end
        e_rd = ref_read(e_addr[5:0], e_wb);
        chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_word_byte", {31'd0, mem_word_byte}, {31'd0, e_wb});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, e_stall});
        chk("pipe_rdata", pipe_rdata, e_rd);
        chk("dbg_ack", {31'd0, dbg_ack}, {31'd0, m_phase == 2});
        chk("dbg_rdata", dbg_rdata, m_rdata);
        if (dbg_ack === 1'b1 && dbg_pending)
            chk("dbg_latency_bound", {31'd0, (cyc - dbg_start) <= LIMIT + 1}, 32'd1);
    endtask

    // Apply this cycle's memory effect and ownership change, then cross the clock edge.
    task automatic advance();
        if (m_phase == 1) begin
            if (dbg_we) ref_write(dbg_addr[5:0], 1'b1, dbg_wdata);
        end else if (pipe_req && pipe_we) begin
            ref_write(pipe_addr[5:0], pipe_word_byte, pipe_wdata);
        end
        if (rst) begin
            m_phase = 0; m_refused = 0; m_rdata = 32'd0;
        end else if (m_phase == 1) begin
            if (!dbg_we) m_rdata = ref_read(dbg_addr[5:0], 1'b1);
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (dbg_req && (!pipe_req || m_refused >= LIMIT - 1)) begin
            m_phase = 1; m_refused = 0;
        end else if (dbg_req) begin
            m_refused = (m_refused + 1 > LIMIT - 1) ? LIMIT - 1 : m_refused + 1;
        end else begin
            m_refused = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; mem_clear = 1'b1;
        pipe_req = 0; pipe_we = 0; pipe_word_byte = 0; pipe_addr = 0; pipe_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
        m_phase = 0; m_refused = 0; m_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; mem_clear = 1'b0;

        // Reset state
        sample();
        chk("t1_stall", {31'd0, pipe_stall}, 32'd0);
        chk("t1_ack", {31'd0, dbg_ack}, 32'd0);
        chk("t1_rdata", dbg_rdata, 32'd0);
        chk("t1_mem_en", {31'd0, mem_en}, 32'd0);
        chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
        advance();

        // Pipeline store, no debug
        pipe_req = 1; pipe_we = 1; pipe_word_byte = 1; pipe_addr = 8; pipe_wdata = 26;
        sample();
        chk("t2_mem_en", {31'd0, mem_en}, 32'd1);
        chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
        chk("t2_mem_addr", mem_addr, 32'd8);
        chk("t2_mem_wdata", mem_wdata, 32'd26);
        chk("t2_stall", {31'd0, pipe_stall}, 32'd0);
        advance();

        // Seed mem[12]=2 through the pipeline
        pipe_addr = 12; pipe_wdata = 2;
        sample(); advance();

        // Debug read alone
        pipe_req = 0; pipe_we = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 12; dbg_wdata = 0;
        sample(); advance();
        sample();
        chk("t3_mem_addr", mem_addr, 32'd12);
        chk("t3_word", {31'd0, mem_word_byte}, 32'd1);
        advance();
        dbg_req = 0;
        sample();
        chk("t3_ack", {31'd0, dbg_ack}, 32'd1);
        chk("t3_rdata", dbg_rdata, 32'd2);
        advance();

        // Contention with continuous pipeline traffic
        pipe_req = 1; pipe_we = 0; pipe_word_byte = 1;
        dbg_req = 1; dbg_we = 0; dbg_addr = 12;
        for (int i = 0; i < 4; i++) begin
            pipe_addr = 32'(4 * i);
            sample();
            chk("t4_stall_early", {31'd0, pipe_stall}, 32'd0);
            chk("t4_pipe_addr", mem_addr, 32'(4 * i));
            advance();
        end
        pipe_addr = 20;
        sample();
        chk("t4_stall_grant", {31'd0, pipe_stall}, 32'd1);
        chk("t4_dbg_addr", mem_addr, 32'd12);
        advance();
        dbg_req = 0;
        sample();
        chk("t4_ack", {31'd0, dbg_ack}, 32'd1);
        chk("t4_stall_ack", {31'd0, pipe_stall}, 32'd0);
        advance();
        pipe_req = 0;

        // Debug write then pipeline load
        dbg_req = 1; dbg_we = 1; dbg_addr = 16; dbg_wdata = 32'h1A;
        sample(); advance();
        sample(); advance();
        dbg_req = 0;
        sample(); advance();
        pipe_req = 1; pipe_we = 0; pipe_word_byte = 1; pipe_addr = 16;
        sample();
        chk("t5_pipe_rdata", pipe_rdata, 32'h1A);
        advance();
        pipe_req = 0;

        // Reset during the debug grant cycle
        dbg_req = 1; dbg_we = 0; dbg_addr = 12;
        sample(); advance();
        rst = 1;
        sample();
        chk("t6_grant_addr", mem_addr, 32'd12);
        advance();
        rst = 0; dbg_req = 0;
        sample();
        chk("t6_no_ack", {31'd0, dbg_ack}, 32'd0);
        chk("t6_rdata", dbg_rdata, 32'd0);
        advance();
        sample();
        chk("t6_no_ack_later", {31'd0, dbg_ack}, 32'd0);
        advance();

        // Randomized traffic against the reference
        for (int n = 0; n < 400; n++) begin
            pipe_req       = ($urandom_range(0, 3) != 0);
            pipe_we        = $urandom_range(0, 1) == 1;
            pipe_word_byte = $urandom_range(0, 1) == 1;
            pipe_addr      = pipe_word_byte ? 32'($urandom_range(0, 15) * 4) : 32'($urandom_range(0, 63));
            pipe_wdata     = $urandom;
            rst            = ($urandom_range(0, 49) == 0);
            if (m_phase == 2) begin
                dbg_req = 0;
            end else if (!dbg_req && m_phase == 0 && $urandom_range(0, 2) == 0) begin
                dbg_req     = 1;
                dbg_we      = $urandom_range(0, 1) == 1;
                dbg_addr    = 32'($urandom_range(0, 15) * 4);
                dbg_wdata   = $urandom;
                dbg_start   = cyc;
                dbg_pending = 1'b1;
            end
            sample();
            if (dbg_req && !rst && (cyc - dbg_start) > LIMIT + 3)
                chk("dbg_starved", 32'(cyc - dbg_start), 32'(LIMIT + 1));
            if (dbg_ack === 1'b1) dbg_pending = 1'b0;
            advance();
            if (rst) begin
                rst = 0; dbg_req = 0; dbg_pending = 1'b0;
            end
        end
        rst = 0; pipe_req = 0; dbg_req = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
